// File: rtl/icache_tag_table.sv
// icache_tag_table
//
// Set-associative tag table for the instruction cache. A fetch PC is looked
// up combinationally and translated to an SRAM fetch-word address
// {set, way, word-in-line}; a miss stalls fetch and, from IDLE, launches a
// line fill towards the memory controller. Replacement uses a per-set
// round-robin pointer that skips a line hit while the pointer names it.
// Hits to resident lines are served while a fill is outstanding. A flush
// pulse (fence.i) invalidates the whole table in one edge.
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous reset, active low
//   IN_lookupValid     fetch lookup this cycle
//   IN_lookupPC        fetch PC (halfword granular)
//   OUT_lookupAddress  {set, way, PC[LINE_OFFS_W-1:FETCH_W]}, valid on hit
//   OUT_hit            lookup valid and tag match
//   OUT_stall          lookup valid and no hit
//   IN_flush           one-cycle pulse, invalidate every line
//   OUT_memReqValid    fill request pending
//   OUT_memReqAddr     line address of the fill
//   OUT_memReqSlot     destination slot {set, way}
//   IN_memReqReady     controller accepts the request
//   IN_memDone         accepted fill completed
//   IN_memErr          accepted fill aborted
module icache_tag_table #(
  parameter int NUM_WAYS    = 2,
  parameter int NUM_SETS    = 4,
  parameter int ADDR_W      = 31,
  parameter int LINE_OFFS_W = 8,
  parameter int FETCH_W     = 3,
  localparam int WAY_W = $clog2(NUM_WAYS),
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int TAG_W = ADDR_W - LINE_OFFS_W - SET_W,
  localparam int LA_W  = SET_W + WAY_W + LINE_OFFS_W - FETCH_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IN_lookupValid,
  input  logic [ADDR_W-1:0]             IN_lookupPC,
  output logic [LA_W-1:0]               OUT_lookupAddress,
  output logic                          OUT_hit,
  output logic                          OUT_stall,
  input  logic                          IN_flush,
  output logic                          OUT_memReqValid,
  output logic [ADDR_W-LINE_OFFS_W-1:0] OUT_memReqAddr,
  output logic [SET_W+WAY_W-1:0]        OUT_memReqSlot,
  input  logic                          IN_memReqReady,
  input  logic                          IN_memDone,
  input  logic                          IN_memErr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;

  logic [NUM_WAYS-1:0]             valid [NUM_SETS];
  logic [TAG_W-1:0]                tags  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]                ptr   [NUM_SETS];

  logic [ADDR_W-LINE_OFFS_W-1:0]   req_addr;
  logic [SET_W-1:0]                req_set;
  logic [WAY_W-1:0]                req_way;
  logic                            discard;

  logic [SET_W-1:0]                lk_set;
  logic [TAG_W-1:0]                lk_tag;
  logic [NUM_WAYS-1:0]             way_match;
  logic                            tag_hit;
  logic [WAY_W-1:0]                hit_way;
  logic [WAY_W-1:0]                victim;
  logic                            victim_found;
  logic                            start_fill;
  logic                            fill_done;
  logic                            second_chance;

  // Fetch-word select bits below FETCH_W do not take part in the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^IN_lookupPC[FETCH_W-1:0];

  assign lk_set = IN_lookupPC[LINE_OFFS_W+SET_W-1:LINE_OFFS_W];
  assign lk_tag = IN_lookupPC[ADDR_W-1:LINE_OFFS_W+SET_W];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_cmp
    assign way_match[gi] = valid[lk_set][gi] && (tags[lk_set][gi] == lk_tag);
  end

  // A valid matching tag is unique within a set, so a priority encode is
  // only used to turn the one-hot match into an index.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_match[w]) hit_way = WAY_W'(w);
    end
  end
  assign tag_hit = |way_match;

  // Lowest invalid way wins; with a full set the round-robin pointer decides.
  always_comb begin
    victim       = ptr[lk_set];
    victim_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !valid[lk_set][w]) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign OUT_hit           = IN_lookupValid && tag_hit;
  assign OUT_stall         = IN_lookupValid && !tag_hit;
  assign OUT_lookupAddress = {lk_set, hit_way, IN_lookupPC[LINE_OFFS_W-1:FETCH_W]};

  assign OUT_memReqValid = (state == REQ);
  assign OUT_memReqAddr  = req_addr;
  assign OUT_memReqSlot  = {req_set, req_way};

  // Second chance only while no fill is in flight, so it never races the
  // pointer update done by a completing fill.
  assign second_chance = (state == IDLE) && IN_lookupValid && tag_hit &&
                         (hit_way == ptr[lk_set]);

  always_comb begin
    state_next = state;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        // A flush in the same cycle would invalidate the victim choice anyway.
        if (IN_lookupValid && !tag_hit && !IN_flush) begin
          state_next = REQ;
          start_fill = 1'b1;
        end
      end
      REQ: begin
        if (IN_memReqReady) state_next = WAIT;
      end
      WAIT: begin
        if (IN_memErr) begin
          state_next = IDLE;
        end else if (IN_memDone) begin
          state_next = IDLE;
          fill_done  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr <= '0;
      req_set  <= '0;
      req_way  <= '0;
      discard  <= 1'b0;
    end else begin
      if (start_fill) begin
        req_addr <= IN_lookupPC[ADDR_W-1:LINE_OFFS_W];
        req_set  <= lk_set;
        req_way  <= victim;
        discard  <= 1'b0;
      end else if (IN_flush && state != IDLE) begin
        // The in-flight line belongs to pre-flush code: let the transfer
        // finish but never mark it valid.
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      if (IN_flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
      end else begin
        if (start_fill)             valid[lk_set][victim]   <= 1'b0;
        if (fill_done && !discard)  valid[req_set][req_way] <= 1'b1;
      end
      if (fill_done)          ptr[req_set] <= req_way + 1'b1;
      else if (second_chance) ptr[lk_set]  <= ptr[lk_set] + 1'b1;
    end
  end

  // Tag storage needs no reset: a tag is only read through its valid bit.
  always_ff @(posedge clk) begin
    if (fill_done && !discard && !IN_flush)
      tags[req_set][req_way] <= req_addr[ADDR_W-LINE_OFFS_W-1:SET_W];
  end

endmodule

// File: tb/tb_icache_tag_table.sv
module tb_icache_tag_table;

  localparam int NUM_WAYS    = 2;
  localparam int NUM_SETS    = 4;
  localparam int ADDR_W      = 31;
  localparam int LINE_OFFS_W = 8;
  localparam int FETCH_W     = 3;
  localparam int LA_W        = 8;
  localparam int RA_W        = ADDR_W - LINE_OFFS_W;
  localparam int SL_W        = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              lookup_valid = 1'b0;
  logic [ADDR_W-1:0] lookup_pc = '0;
  logic [LA_W-1:0]   lookup_address;
  logic              hit, stall;
  logic              flush = 1'b0;
  logic              req_valid;
  logic [RA_W-1:0]   req_addr;
  logic [SL_W-1:0]   req_slot;
  logic              req_ready = 1'b0;
  logic              mem_done = 1'b0;
  logic              mem_err = 1'b0;

  icache_tag_table #(
    .NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .ADDR_W(ADDR_W),
    .LINE_OFFS_W(LINE_OFFS_W), .FETCH_W(FETCH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .IN_lookupValid(lookup_valid), .IN_lookupPC(lookup_pc),
    .OUT_lookupAddress(lookup_address), .OUT_hit(hit), .OUT_stall(stall),
    .IN_flush(flush),
    .OUT_memReqValid(req_valid), .OUT_memReqAddr(req_addr), .OUT_memReqSlot(req_slot),
    .IN_memReqReady(req_ready), .IN_memDone(mem_done), .IN_memErr(mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic              lv;
    logic [ADDR_W-1:0] pc;
    logic              fl, rdy, dn, er;
    logic              e_hit, e_stall;
    logic [LA_W-1:0]   e_la;
    logic              e_rv;
    logic [RA_W-1:0]   e_ra;
    logic [SL_W-1:0]   e_sl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic lv, logic [ADDR_W-1:0] pc, logic fl, logic rdy,
                             logic dn, logic er, logic e_hit, logic e_stall,
                             logic [LA_W-1:0] e_la, logic e_rv, logic [RA_W-1:0] e_ra,
                             logic [SL_W-1:0] e_sl);
    vec_t r;
    r.lv = lv; r.pc = pc; r.fl = fl; r.rdy = rdy; r.dn = dn; r.er = er;
    r.e_hit = e_hit; r.e_stall = e_stall; r.e_la = e_la;
    r.e_rv = e_rv; r.e_ra = e_ra; r.e_sl = e_sl;
    return r;
  endfunction

  // One cycle: drive after the falling edge, sample 1 ns later (well before
  // the next rising edge), compare against the expected record.
  task automatic apply(string name, vec_t r);
    @(negedge clk);
    lookup_valid = r.lv; lookup_pc = r.pc; flush = r.fl;
    req_ready = r.rdy; mem_done = r.dn; mem_err = r.er;
    #1;
    check({name, " hit"}, hit, r.e_hit);
    check({name, " stall"}, stall, r.e_stall);
    if (r.e_hit) check({name, " lookupAddress"}, lookup_address, r.e_la);
    check({name, " memReqValid"}, req_valid, r.e_rv);
    if (r.e_rv) begin
      check({name, " memReqAddr"}, req_addr, r.e_ra);
      check({name, " memReqSlot"}, req_slot, r.e_sl);
    end
    $display("%s: lv=%0d pc=0x%0h fl=%0d rdy=%0d done=%0d err=%0d -> hit=%0d stall=%0d la=0x%0h reqV=%0d addr=0x%0h slot=%0d",
             name, r.lv, r.pc, r.fl, r.rdy, r.dn, r.er, hit, stall, lookup_address,
             req_valid, req_addr, req_slot);
  endtask

  // Behavioural reference for the random phase: plain arrays and a
  // "fill in flight" descriptor.
  bit          m_valid [NUM_SETS][NUM_WAYS];
  int unsigned m_tag   [NUM_SETS][NUM_WAYS];
  int unsigned m_ptr   [NUM_SETS];
  int          m_phase;          // 0 no fill, 1 asking the controller, 2 transferring
  int unsigned m_line, m_sset, m_sway;
  bit          m_discard;

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = 0;
      end
    end
    m_phase = 0; m_line = 0; m_sset = 0; m_sway = 0; m_discard = 0;
  endtask

  initial begin
    int unsigned tag_pool [3];
    int unsigned fills;
    tag_pool[0] = 0; tag_pool[1] = 1; tag_pool[2] = 'h1FFFFF;

    // ---------------- reset state ----------------
    lookup_valid = 1'b1; lookup_pc = 'h100;
    #2;
    check("reset hit", hit, 0);
    check("reset stall", stall, 1);
    check("reset memReqValid", req_valid, 0);
    check("reset memReqAddr", req_addr, 0);
    check("reset memReqSlot", req_slot, 0);
    @(negedge clk);
    lookup_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table: cold miss, replacement, error ----------------
    tbl.push_back(v(1,'h100,0,0,0,0, 0,1,0,    0,0,0));  // cold miss set1
    tbl.push_back(v(0,0,    0,1,0,0, 0,0,0,    1,1,2));  // request, accepted
    tbl.push_back(v(0,0,    0,0,0,0, 0,0,0,    0,0,0));
    tbl.push_back(v(0,0,    0,0,0,0, 0,0,0,    0,0,0));
    tbl.push_back(v(0,0,    0,0,0,0, 0,0,0,    0,0,0));
    tbl.push_back(v(0,0,    0,0,0,0, 0,0,0,    0,0,0));
    tbl.push_back(v(0,0,    0,0,1,0, 0,0,0,    0,0,0));  // done
    tbl.push_back(v(1,'h108,0,0,0,0, 1,0,'h41, 0,0,0));
    tbl.push_back(v(1,'h500,0,0,0,0, 0,1,0,    0,0,0));  // miss -> way1
    tbl.push_back(v(0,0,    0,1,0,0, 0,0,0,    1,5,3));
    tbl.push_back(v(0,0,    0,0,1,0, 0,0,0,    0,0,0));  // ptr[1] wraps to 0
    tbl.push_back(v(1,'h500,0,0,0,0, 1,0,'h60, 0,0,0));
    tbl.push_back(v(1,'h100,0,0,0,0, 1,0,'h40, 0,0,0));  // second chance, ptr[1]=1
    tbl.push_back(v(1,'h900,0,0,0,0, 0,1,0,    0,0,0));  // victim way1 (0x500)
    tbl.push_back(v(0,0,    0,1,0,0, 0,0,0,    1,9,3));
    tbl.push_back(v(0,0,    0,0,1,0, 0,0,0,    0,0,0));
    tbl.push_back(v(1,'h100,0,0,0,0, 1,0,'h40, 0,0,0));  // ptr 0->1
    tbl.push_back(v(1,'h900,0,0,0,0, 1,0,'h60, 0,0,0));  // ptr 1->0
    tbl.push_back(v(1,'h500,0,0,0,0, 0,1,0,    0,0,0));  // victim way0
    tbl.push_back(v(0,0,    0,0,0,0, 0,0,0,    1,5,2));  // held, not ready
    tbl.push_back(v(0,0,    0,1,0,0, 0,0,0,    1,5,2));
    tbl.push_back(v(0,0,    0,0,0,1, 0,0,0,    0,0,0));  // bus error
    tbl.push_back(v(1,'h100,0,0,0,0, 0,1,0,    0,0,0));  // way0 stayed invalid
    tbl.push_back(v(0,0,    0,1,0,0, 0,0,0,    1,1,2));  // same slot again
    tbl.push_back(v(0,0,    0,0,1,0, 0,0,0,    0,0,0));
    tbl.push_back(v(1,'h100,0,0,0,0, 1,0,'h40, 0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("row%0d", i), tbl[i]);

    // ---------------- flush during WAIT, then flush with done ----------------
    apply("flushA1", v(1,'h300,0,0,0,0, 0,1,0,    0,0,0));
    apply("flushA2", v(0,0,    0,1,0,0, 0,0,0,    1,3,6));
    apply("flushA3", v(0,0,    1,0,0,0, 0,0,0,    0,0,0));
    apply("flushA4", v(0,0,    0,0,1,0, 0,0,0,    0,0,0));
    apply("flushA5", v(1,'h300,0,0,0,0, 0,1,0,    0,0,0));
    apply("flushA6", v(0,0,    0,1,0,0, 0,0,0,    1,3,6));
    apply("flushA7", v(0,0,    0,0,0,0, 0,0,0,    0,0,0));
    apply("flushA8", v(0,0,    1,0,1,0, 0,0,0,    0,0,0));
    apply("flushA9", v(1,'h300,0,0,0,0, 0,1,0,    0,0,0));
    apply("flushA10",v(0,0,    0,1,0,0, 0,0,0,    1,3,6));
    apply("flushA11",v(0,0,    0,0,1,0, 0,0,0,    0,0,0));
    apply("flushA12",v(1,'h300,0,0,0,0, 1,0,'hC0, 0,0,0));
    apply("flushA13",v(1,'h100,0,0,0,0, 0,1,0,    0,0,0));
    apply("flushA14",v(0,0,    0,1,0,0, 0,0,0,    1,1,2));
    apply("flushA15",v(0,0,    0,0,1,0, 0,0,0,    0,0,0));

    // ---------------- hit-under-miss ----------------
    apply("hum1", v(1,'h200,0,0,0,0, 0,1,0,    0,0,0));
    apply("hum2", v(0,0,    0,1,0,0, 0,0,0,    1,2,4));
    apply("hum3", v(1,'h100,0,0,0,0, 1,0,'h40, 0,0,0));
    apply("hum4", v(1,'hA00,0,0,0,0, 0,1,0,    0,0,0));
    apply("hum5", v(1,'hA00,0,0,0,0, 0,1,0,    0,0,0));
    apply("hum6", v(1,'hA00,0,0,1,0, 0,1,0,    0,0,0));
    apply("hum7", v(1,'hA00,0,0,0,0, 0,1,0,    0,0,0));
    apply("hum8", v(0,0,    0,0,0,0, 0,0,0,    1,'hA,5));

    // ---------------- reset in the middle of a request ----------------
    #1;
    rst = 1'b0;
    #1;
    check("midreset memReqValid", req_valid, 0);
    check("midreset memReqAddr", req_addr, 0);
    check("midreset memReqSlot", req_slot, 0);
    $display("midreset: reqV=%0d addr=0x%0h slot=%0d", req_valid, req_addr, req_slot);
    @(negedge clk);
    rst = 1'b1;
    apply("postrst1", v(1,'h100,0,0,0,0, 0,1,0, 0,0,0));
    apply("postrst2", v(1,'h200,0,0,0,0, 0,1,0, 1,1,2));
    apply("postrst3", v(1,'h300,0,0,0,0, 0,1,0, 1,1,2));

    // ---------------- randomized run against the reference ----------------
    @(negedge clk);
    rst = 1'b0; lookup_valid = 0; flush = 0; req_ready = 0; mem_done = 0; mem_err = 0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    fills = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int unsigned s, t, pc, ev, e_la;
      bit lv, fl, rdy, dn, er, e_hit;
      int e_way, vict, old_phase;
      @(negedge clk);
      lv  = ($urandom_range(0, 3) != 0);
      s   = $urandom_range(0, NUM_SETS - 1);
      t   = tag_pool[$urandom_range(0, 2)];
      pc  = (t << 10) | (s << 8) | $urandom_range(0, 255);
      fl  = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      dn  = ($urandom_range(0, 5) == 0);
      er  = ($urandom_range(0, 13) == 0);
      lookup_valid = lv; lookup_pc = pc; flush = fl;
      req_ready = rdy; mem_done = dn; mem_err = er;
      #1;
      s = (pc >> LINE_OFFS_W) % NUM_SETS;
      t = pc >> (LINE_OFFS_W + 2);
      e_hit = 0; e_way = 0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (m_valid[s][w] && m_tag[s][w] == t) begin e_hit = 1; e_way = w; end
      e_la = s * 64 + e_way * 32 + (pc % 256) / 8;
      check("rnd hit", hit, lv && e_hit);
      check("rnd stall", stall, lv && !e_hit);
      if (lv && e_hit) check("rnd lookupAddress", lookup_address, e_la);
      check("rnd memReqValid", req_valid, m_phase == 1);
      check("rnd memReqAddr", req_addr, m_line);
      check("rnd memReqSlot", req_slot, m_sset * 2 + m_sway);

      // reference update for the coming rising edge
      old_phase = m_phase;
      if (m_phase == 0) begin
        if (lv && e_hit && e_way == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % NUM_WAYS;
        if (lv && !e_hit && !fl) begin
          vict = -1;
          for (int w = NUM_WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) vict = w;
          if (vict < 0) vict = m_ptr[s];
          m_valid[s][vict] = 0;
          m_line = pc >> LINE_OFFS_W; m_sset = s; m_sway = vict;
          m_discard = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (rdy) m_phase = 2;
      end else begin
        if (er) begin
          m_phase = 0;
          fills++;
          $display("rnd fill %0d: line=0x%0h slot=%0d aborted", fills, m_line, m_sset * 2 + m_sway);
        end else if (dn) begin
          if (!m_discard && !fl) begin
            m_valid[m_sset][m_sway] = 1;
            m_tag[m_sset][m_sway] = m_line >> 2;
          end
          m_ptr[m_sset] = (m_sway + 1) % NUM_WAYS;
          m_phase = 0;
          fills++;
          $display("rnd fill %0d: line=0x%0h slot=%0d done discard=%0d flush=%0d",
                   fills, m_line, m_sset * 2 + m_sway, m_discard, fl);
        end
      end
      if (fl) begin
        for (int a = 0; a < NUM_SETS; a++)
          for (int w = 0; w < NUM_WAYS; w++) m_valid[a][w] = 0;
        if (old_phase != 0) m_discard = 1;
      end
      ev = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
